// File: rtl/bcd2bin.sv
// rtl/bcd2bin.sv - two-digit BCD to 7-bit binary converter, one result bit per OP cycle
module bcd2bin (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  output logic       ready,
  output logic       done_tick,
  output logic [6:0] bin
);

  typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

  state_t     state_q, state_d;
  logic [6:0] a_q, a_d;
  logic [6:0] b_q, b_d;
  logic [6:0] c_q, c_d;
  logic [6:0] bin_q, bin_d;
  logic [2:0] n_q, n_d;
  logic [1:0] cy_q, cy_d;
  logic [2:0] sum;

  // Bit-serial three-operand add of 8*bcd1 + 2*bcd1 + bcd0; wraps naturally mod 128.
  assign sum = {2'b00, a_q[0]} + {2'b00, b_q[0]} + {2'b00, c_q[0]} + {1'b0, cy_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      bin_q   <= '0;
      n_q     <= '0;
      cy_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      bin_q   <= bin_d;
      n_q     <= n_d;
      cy_q    <= cy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    bin_d     = bin_q;
    n_d       = n_q;
    cy_d      = cy_q;
    ready     = 1'b0;
    done_tick = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          a_d     = {bcd1, 3'b000};
          b_d     = {2'b00, bcd1, 1'b0};
          c_d     = {3'b000, bcd0};
          n_d     = '0;
          cy_d    = '0;
          state_d = OP;
        end
      end
      OP: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = c_q >> 1;
        cy_d  = sum[2:1];
        bin_d = {sum[0], bin_q[6:1]};
        n_d   = n_q + 3'd1;
        if (n_q == 3'd6) state_d = DONE;
      end
      DONE: begin
        done_tick = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bin = bin_q;

endmodule

// File: tb/tb_bcd2bin.sv
// tb/tb_bcd2bin.sv - table-driven and sequence checks for bcd2bin
module tb_bcd2bin;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] bcd1;
  logic [3:0] bcd0;
  logic       ready;
  logic       done_tick;
  logic [6:0] bin;

  int checks;
  int failures;

  bcd2bin dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bcd1      (bcd1),
    .bcd0      (bcd0),
    .ready     (ready),
    .done_tick (done_tick),
    .bin       (bin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] b1;
    logic [3:0] b0;
    logic [6:0] exp_bin;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done_tick === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  // Called at a negedge while idle; returns just after the accept edge.
  task automatic accept(input logic [3:0] b1, input logic [3:0] b0);
    bcd1  = b1;
    bcd0  = b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_conv(input string name, input logic [3:0] b1, input logic [3:0] b0,
                          input logic [6:0] exp_bin);
    int lat;
    accept(b1, b0);
    @(negedge clk);
    chk({name, "_ready_op"}, ready, 0);
    lat = 0;
    wait_done(lat);
    chk({name, "_latency"}, lat + 1, 8);
    chk({name, "_bin"}, bin, exp_bin);
    @(negedge clk);
    chk({name, "_ready_after"}, ready, 1);
    chk({name, "_done_low"}, done_tick, 0);
  endtask

  initial begin
    int lat;
    int bad;
    checks   = 0;
    failures = 0;
    start    = 1'b0;
    bcd1     = 4'd0;
    bcd0     = 4'd0;
    reset    = 1'b0;

    vecs[0]  = '{4'd0,  4'd0,  7'd0};
    vecs[1]  = '{4'd9,  4'd9,  7'd99};
    vecs[2]  = '{4'd5,  4'd5,  7'd55};
    vecs[3]  = '{4'd0,  4'd9,  7'd9};
    vecs[4]  = '{4'd9,  4'd0,  7'd90};
    vecs[5]  = '{4'd4,  4'd2,  7'd42};
    vecs[6]  = '{4'd1,  4'd0,  7'd10};
    vecs[7]  = '{4'd3,  4'd7,  7'd37};
    vecs[8]  = '{4'd15, 4'd15, 7'h25};
    vecs[9]  = '{4'd10, 4'd0,  7'd100};
    vecs[10] = '{4'd12, 4'd9,  7'd1};
    vecs[11] = '{4'd15, 4'd0,  7'd22};
    vecs[12] = '{4'd0,  4'd15, 7'd15};

    #1;
    chk("rst_ready", ready, 1);
    chk("rst_done", done_tick, 0);
    chk("rst_bin", bin, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      run_conv($sformatf("vec%0d", i), vecs[i].b1, vecs[i].b0, vecs[i].exp_bin);
    end

    // Back-to-back with start held high
    begin
      logic [3:0] s1[4];
      logic [3:0] s0[4];
      logic [6:0] se[4];
      s1 = '{4'd9, 4'd5, 4'd0, 4'd9};
      s0 = '{4'd9, 4'd5, 4'd9, 4'd0};
      se = '{7'h63, 7'h37, 7'h09, 7'h5A};
      bcd1  = s1[0];
      bcd0  = s0[0];
      start = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
        lat = 0;
        wait_done(lat);
        if (k == 0) chk("b2b_lat0", lat, 8);
        else        chk($sformatf("b2b_spacing%0d", k), lat, 9);
        chk($sformatf("b2b_bin%0d", k), bin, se[k]);
        if (k < 3) begin
          bcd1 = s1[k + 1];
          bcd0 = s0[k + 1];
        end else begin
          start = 1'b0;
        end
      end
      @(negedge clk);
      chk("b2b_ready_end", ready, 1);
      chk("b2b_done_end", done_tick, 0);
    end

    // Inputs changing and start pulsing during OP are ignored
    @(negedge clk);
    accept(4'd3, 4'd4);
    @(negedge clk);
    @(negedge clk);
    bcd1  = 4'd9;
    bcd0  = 4'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    wait_done(lat);
    chk("opign_lat", lat, 5);
    chk("opign_bin", bin, 34);
    @(negedge clk);
    chk("opign_ready", ready, 1);

    // Reset three cycles into OP
    accept(4'd7, 4'd7);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_done", done_tick, 0);
    chk("abort_bin", bin, 0);
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_tick !== 1'b0 || ready !== 1'b1) bad++;
    end
    chk("abort_no_done", bad, 0);
    run_conv("post_abort", 4'd4, 4'd2, 7'h2A);

    // Idle hold
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready !== 1'b1 || done_tick !== 1'b0 || bin !== 7'h2A) bad++;
    end
    chk("idle_hold", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/bcd2bin.md
BCD2BIN -- requirements
Module: bcd2bin

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset; the block is in reset while reset=0.
REQ-003 SHALL have port: start  input  1  conversion request; sampled only while idle.
REQ-004 SHALL have port: bcd1  input  4  BCD tens digit.
REQ-005 SHALL have port: bcd0  input  4  BCD units digit.
REQ-006 SHALL have port: ready  output  1  high exactly while in IDLE.
REQ-007 SHALL have port: done_tick  output  1  one-cycle pulse marking a valid result.
REQ-008 SHALL have port: bin  output  7  binary result, bcd1*10+bcd0.
REQ-009 SHALL have no parameters.

Function
REQ-010 SHALL implement an FSM with three states: IDLE, OP, DONE.
REQ-011 IDLE: ready=1; on a rising edge with start=1 -> capture bcd1/bcd0 into internal registers, clear the iteration counter, go to OP (the accept edge).
REQ-012 IDLE with start=0 SHALL remain in IDLE; bin holds its last value.
REQ-013 OP SHALL last exactly 7 clock cycles (one per result bit); any iterative method is permitted, e.g. BCD shift-right with subtract-3 correction, or shift-and-add.
REQ-014 After OP, SHALL enter DONE for exactly 1 cycle: done_tick=1 and bin valid; then return unconditionally to IDLE.
REQ-015 Latency: done_tick SHALL be high in the 8th cycle after the accept edge, i.e. the 8th clock after acceptance moves DONE->IDLE.
REQ-016 bin SHALL hold the result from DONE through IDLE until the next accept edge; bin content during OP is unspecified.
REQ-017 SHALL ignore start, bcd1 and bcd0 in OP and DONE; captured operands stay fixed for the whole conversion.
REQ-018 Back-to-back: if start=1 in the IDLE cycle immediately after DONE, a new conversion SHALL be accepted on that edge using the bcd1/bcd0 present at that edge. Minimum throughput is one conversion per 9 cycles.
REQ-019 Arithmetic: for digits 0..9, bin = 10*bcd1 + bcd0, range 0..99 (0x00..0x63).
REQ-020 Non-BCD digits (>9) SHALL produce bin = (10*bcd1 + bcd0) mod 128, with no error flag.
REQ-021 done_tick SHALL never be asserted outside DONE and SHALL never last longer than 1 cycle.

Reset
REQ-022 reset=0 SHALL immediately force: state=IDLE, ready=1, done_tick=0, bin=0, internal operand/counter registers=0.
REQ-023 reset asserted during OP or DONE SHALL abort the conversion with no done_tick; after release, the block is in IDLE.
REQ-024 After reset release, the first rising edge with start=1 SHALL be an accept edge.

Verification
REQ-025 Reset, then start=1 with bcd1=0, bcd0=0 -> done_tick 8 cycles after accept, bin=0x00, ready=1 on the following cycle.
REQ-026 Hold start=1 continuously; present (9,9), (5,5), (0,9), (9,0), each loaded on the done_tick edge -> bin=0x63, 0x37, 0x09, 0x5A in order; exactly one done_tick per conversion, 9-cycle spacing.
REQ-027 Change bcd1/bcd0 and pulse start during OP -> no effect; the result matches the operands captured at accept.
REQ-028 Assert reset 3 cycles into OP -> no done_tick, bin=0, ready=1; a fresh conversion of (4,2) then yields bin=0x2A.
REQ-029 Apply bcd1=15, bcd0=15 -> bin=0x25 (165 mod 128).
REQ-030 With start=0 for 20 idle cycles after a result -> ready stays 1, done_tick stays 0, bin is unchanged.
